// File: rtl/zcu106_reset_pkg.sv
// Shared definitions for the ZCU106 reset sequencer.
//   state_e   : sequencer states (HOLD, RELEASE, RUN, QUIESCE)
//   cause_e   : encoding of the last reset cause reported on `cause`
//   cnt_width : width of the shared down-counter for a given parameter set
package zcu106_reset_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_QUIESCE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_PLL = 2'b01,
    CAUSE_BTN = 2'b10,
    CAUSE_SW  = 2'b11
  } cause_e;

  // clog2 of the largest interval, plus one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned stagger_cycles,
                                            input int unsigned ack_timeout);
    int unsigned m;
    m = hold_cycles;
    if (stagger_cycles > m) m = stagger_cycles;
    if (ack_timeout > m) m = ack_timeout;
    return int'($clog2(m)) + 1;
  endfunction

endpackage

// File: rtl/zcu106_reset_timer.sv
// Shared down-counter used for the hold, stagger and acknowledge intervals.
// Ports:
//   clock      : sole clock
//   load_i     : load load_val_i this edge (wins over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement this edge; saturates at zero
//   zero_o     : counter currently reads zero
// The owner asserts load_i during its reset, so no local reset is needed.
module zcu106_reset_timer
  import zcu106_reset_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clock,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/zcu106_reset_seq.sv
// ZCU106 reset sequencer: holds all reset domains until the clock is locked
// and the button is idle for HOLD_CYCLES clean cycles, then releases domains
// one at a time (bit 0 first) every STAGGER_CYCLES edges. A software reset
// request in RUN first asks the system to drain (quiesce_req) and waits up
// to ACK_TIMEOUT cycles for quiesce_ack before re-entering HOLD.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   pll_locked     : clock-generator lock (synchronous)
//   btn_reset      : debounced push-button reset, active-high
//   sw_reset_req   : single-cycle software reset request
//   quiesce_ack    : system drained, level
//   quiesce_req    : drain request, level
//   domain_reset   : per-domain active-high resets
//   busy           : high unless in RUN
//   cause          : last reset cause (00 POR, 01 PLL, 10 BTN, 11 SW)
//   ack_timeout    : sticky, last quiesce ended by timeout
// All outputs come straight from registers.
module zcu106_reset_seq
  import zcu106_reset_pkg::*;
#(
  parameter int unsigned N_DOMAINS      = 4,
  parameter int unsigned HOLD_CYCLES    = 256,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT    = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 pll_locked,
  input  logic                 btn_reset,
  input  logic                 sw_reset_req,
  input  logic                 quiesce_ack,
  output logic                 quiesce_req,
  output logic [N_DOMAINS-1:0] domain_reset,
  output logic                 busy,
  output logic [1:0]           cause,
  output logic                 ack_timeout
);

  localparam int unsigned CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, ACK_TIMEOUT);

  // HOLD counts from the first clean edge with HOLD_CYCLES preloaded, so
  // the release lands HOLD_CYCLES edges after it. Stagger and timeout are
  // measured from the loading edge itself, hence the minus one.
  localparam logic [CW-1:0] LD_HOLD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] LD_STAG = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] LD_ACK  = CW'(ACK_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic   [N_DOMAINS-1:0] dom_q, dom_d;
  logic                   qreq_q, qreq_d;
  logic                   busy_q, busy_d;
  cause_e                 cause_q, cause_d;
  logic                   ato_q, ato_d;

  logic                   clean;
  logic   [N_DOMAINS-1:0] next_mask;
  logic                   tmr_load;
  logic   [CW-1:0]        tmr_val;
  logic                   tmr_dec;
  logic                   tmr_zero;

  zcu106_reset_timer #(
    .WIDTH(CW)
  ) u_timer (
    .clock      (clock),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    dom_d    = dom_q;
    qreq_d   = qreq_q;
    cause_d  = cause_q;
    ato_d    = ato_q;
    tmr_load = 1'b0;
    tmr_val  = LD_HOLD;
    tmr_dec  = 1'b0;

    clean = pll_locked && !btn_reset;
    // Domains still in reset form a contiguous high block; shifting left
    // releases the lowest one. In HOLD the mask is all ones, so the same
    // shift releases bit 0, and an empty result means the last is out.
    next_mask = dom_q << 1;

    if (!clean) begin
      state_d  = ST_HOLD;
      dom_d    = '1;
      qreq_d   = 1'b0;
      cause_d  = !pll_locked ? CAUSE_PLL : CAUSE_BTN;
      tmr_load = 1'b1;
      tmr_val  = LD_HOLD;
    end else begin
      unique case (state_q)
        ST_HOLD, ST_RELEASE: begin
          if (tmr_zero) begin
            dom_d = next_mask;
            if (next_mask == '0) begin
              state_d = ST_RUN;
            end else begin
              state_d  = ST_RELEASE;
              tmr_load = 1'b1;
              tmr_val  = LD_STAG;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_RUN: begin
          if (sw_reset_req) begin
            state_d  = ST_QUIESCE;
            qreq_d   = 1'b1;
            ato_d    = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = LD_ACK;
          end
        end
        ST_QUIESCE: begin
          if (quiesce_ack || tmr_zero) begin
            state_d  = ST_HOLD;
            dom_d    = '1;
            qreq_d   = 1'b0;
            cause_d  = CAUSE_SW;
            // An acknowledge on the expiry edge still counts as drained.
            ato_d    = !quiesce_ack;
            tmr_load = 1'b1;
            tmr_val  = LD_HOLD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: begin
          state_d  = ST_HOLD;
          dom_d    = '1;
          qreq_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
        end
      endcase
    end

    if (!reset_n) begin
      tmr_load = 1'b1;
      tmr_val  = LD_HOLD;
      tmr_dec  = 1'b0;
    end

    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      dom_q   <= '1;
      qreq_q  <= 1'b0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
      ato_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dom_q   <= dom_d;
      qreq_q  <= qreq_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
      ato_q   <= ato_d;
    end
  end

  assign quiesce_req  = qreq_q;
  assign domain_reset = dom_q;
  assign busy         = busy_q;
  assign cause        = cause_q;
  assign ack_timeout  = ato_q;

endmodule

// File: tb/tb_zcu106_reset_seq.sv
module tb_zcu106_reset_seq;

  localparam int ND = 4;
  localparam int HC = 8;
  localparam int SC = 2;
  localparam int AT = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          pll_locked;
  logic          btn_reset;
  logic          sw_reset_req;
  logic          quiesce_ack;
  logic          quiesce_req;
  logic [ND-1:0] domain_reset;
  logic          busy;
  logic [1:0]    cause;
  logic          ack_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  zcu106_reset_seq #(
    .N_DOMAINS      (ND),
    .HOLD_CYCLES    (HC),
    .STAGGER_CYCLES (SC),
    .ACK_TIMEOUT    (AT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .btn_reset    (btn_reset),
    .sw_reset_req (sw_reset_req),
    .quiesce_ack  (quiesce_ack),
    .quiesce_req  (quiesce_req),
    .domain_reset (domain_reset),
    .busy         (busy),
    .cause        (cause),
    .ack_timeout  (ack_timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected domain_reset k edges after the first clean edge in HOLD:
  // domain i falls at edge HC + SC*i.
  function automatic logic [ND-1:0] exp_dr(input int k);
    logic [ND-1:0] r;
    for (int i = 0; i < ND; i++) r[i] = (k < HC + SC * i);
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b1; btn_reset = 1'b0;
    sw_reset_req = 1'b0; quiesce_ack = 1'b0;
    repeat (3) step();
    n_cmp++; if (domain_reset !== 4'b1111) begin n_bad++; $display("FAIL rst_dr got %b want 1111", domain_reset); end
    n_cmp++; if (quiesce_req !== 1'b0) begin n_bad++; $display("FAIL rst_qreq got %b want 0", quiesce_req); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got %b want 1", busy); end
    n_cmp++; if (cause !== 2'b00) begin n_bad++; $display("FAIL rst_cause got %b want 00", cause); end
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_ato got %b want 0", ack_timeout); end
  endtask

  task automatic test_por();
    reset_n = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      step();
      n_cmp++; if (domain_reset !== exp_dr(k)) begin n_bad++; $display("FAIL por_dr k=%0d got %b want %b", k, domain_reset, exp_dr(k)); end
      n_cmp++; if (busy !== (k < 14)) begin n_bad++; $display("FAIL por_busy k=%0d got %b want %b", k, busy, (k < 14)); end
    end
    n_cmp++; if (cause !== 2'b00) begin n_bad++; $display("FAIL por_cause got %b want 00", cause); end
  endtask

  task automatic test_soft_ack();
    sw_reset_req = 1'b1; step(); sw_reset_req = 1'b0;
    n_cmp++; if (quiesce_req !== 1'b1) begin n_bad++; $display("FAIL sack_qreq0 got %b want 1", quiesce_req); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sack_busy got %b want 1", busy); end
    n_cmp++; if (domain_reset !== 4'b0000) begin n_bad++; $display("FAIL sack_dr_held got %b want 0000", domain_reset); end
    for (int i = 1; i <= 2; i++) begin
      step();
      n_cmp++; if (quiesce_req !== 1'b1) begin n_bad++; $display("FAIL sack_qreq i=%0d got %b want 1", i, quiesce_req); end
    end
    quiesce_ack = 1'b1; step(); quiesce_ack = 1'b0;
    n_cmp++; if (quiesce_req !== 1'b0) begin n_bad++; $display("FAIL sack_qreq_end got %b want 0", quiesce_req); end
    n_cmp++; if (domain_reset !== 4'b1111) begin n_bad++; $display("FAIL sack_dr got %b want 1111", domain_reset); end
    n_cmp++; if (cause !== 2'b11) begin n_bad++; $display("FAIL sack_cause got %b want 11", cause); end
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL sack_ato got %b want 0", ack_timeout); end
    for (int k = 0; k <= 14; k++) begin
      step();
      n_cmp++; if (domain_reset !== exp_dr(k)) begin n_bad++; $display("FAIL sack_rel k=%0d got %b want %b", k, domain_reset, exp_dr(k)); end
    end
  endtask

  task automatic test_timeout();
    sw_reset_req = 1'b1; step(); sw_reset_req = 1'b0;
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_ato0 got %b want 0", ack_timeout); end
    for (int i = 0; i < AT - 1; i++) begin
      step();
      n_cmp++; if (quiesce_req !== 1'b1) begin n_bad++; $display("FAIL tmo_qreq i=%0d got %b want 1", i, quiesce_req); end
    end
    step();
    n_cmp++; if (quiesce_req !== 1'b0) begin n_bad++; $display("FAIL tmo_qreq_end got %b want 0", quiesce_req); end
    n_cmp++; if (domain_reset !== 4'b1111) begin n_bad++; $display("FAIL tmo_dr got %b want 1111", domain_reset); end
    n_cmp++; if (ack_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_ato got %b want 1", ack_timeout); end
    n_cmp++; if (cause !== 2'b11) begin n_bad++; $display("FAIL tmo_cause got %b want 11", cause); end
    repeat (15) step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_run got busy %b want 0", busy); end
    // Acknowledge arriving on the expiry edge: exit counts as acknowledged.
    sw_reset_req = 1'b1; step(); sw_reset_req = 1'b0;
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_ato_clear got %b want 0", ack_timeout); end
    repeat (AT - 1) step();
    n_cmp++; if (quiesce_req !== 1'b1) begin n_bad++; $display("FAIL tmo_co_qreq got %b want 1", quiesce_req); end
    quiesce_ack = 1'b1; step(); quiesce_ack = 1'b0;
    n_cmp++; if (quiesce_req !== 1'b0) begin n_bad++; $display("FAIL tmo_co_exit got %b want 0", quiesce_req); end
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_co_ato got %b want 0", ack_timeout); end
    repeat (15) step();
    n_cmp++; if (domain_reset !== 4'b0000) begin n_bad++; $display("FAIL tmo_co_run got %b want 0000", domain_reset); end
  endtask

  task automatic test_glitch();
    pll_locked = 1'b0; step(); pll_locked = 1'b1;
    n_cmp++; if (domain_reset !== 4'b1111) begin n_bad++; $display("FAIL gl_dr got %b want 1111", domain_reset); end
    n_cmp++; if (cause !== 2'b01) begin n_bad++; $display("FAIL gl_cause got %b want 01", cause); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL gl_busy got %b want 1", busy); end
    repeat (5) step();
    pll_locked = 1'b0; step(); pll_locked = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      step();
      n_cmp++; if (domain_reset !== exp_dr(k)) begin n_bad++; $display("FAIL gl_rel k=%0d got %b want %b", k, domain_reset, exp_dr(k)); end
    end
    n_cmp++; if (cause !== 2'b01) begin n_bad++; $display("FAIL gl_cause_end got %b want 01", cause); end
  endtask

  task automatic test_priority();
    btn_reset = 1'b1; step(); btn_reset = 1'b0;
    n_cmp++; if (cause !== 2'b10) begin n_bad++; $display("FAIL pr_btn_cause got %b want 10", cause); end
    repeat (10) step();
    n_cmp++; if (domain_reset !== 4'b1110) begin n_bad++; $display("FAIL pr_mid got %b want 1110", domain_reset); end
    btn_reset = 1'b1; pll_locked = 1'b0; step(); btn_reset = 1'b0; pll_locked = 1'b1;
    n_cmp++; if (domain_reset !== 4'b1111) begin n_bad++; $display("FAIL pr_dr got %b want 1111", domain_reset); end
    n_cmp++; if (cause !== 2'b01) begin n_bad++; $display("FAIL pr_cause got %b want 01", cause); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pr_busy got %b want 1", busy); end
    sw_reset_req = 1'b1; step(); sw_reset_req = 1'b0;
    n_cmp++; if (quiesce_req !== 1'b0) begin n_bad++; $display("FAIL pr_sw_hold got %b want 0", quiesce_req); end
    for (int k = 1; k <= 14; k++) begin
      step();
      n_cmp++; if (domain_reset !== exp_dr(k)) begin n_bad++; $display("FAIL pr_rel k=%0d got %b want %b", k, domain_reset, exp_dr(k)); end
    end
    quiesce_ack = 1'b1; repeat (2) step(); quiesce_ack = 1'b0;
    n_cmp++; if (quiesce_req !== 1'b0) begin n_bad++; $display("FAIL pr_noqueue got %b want 0", quiesce_req); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pr_ack_ign got busy %b want 0", busy); end
    n_cmp++; if (domain_reset !== 4'b0000) begin n_bad++; $display("FAIL pr_ack_dr got %b want 0000", domain_reset); end
  endtask

  task automatic test_mid_reset();
    sw_reset_req = 1'b1; step(); sw_reset_req = 1'b0;
    n_cmp++; if (quiesce_req !== 1'b1) begin n_bad++; $display("FAIL mr_q got %b want 1", quiesce_req); end
    step();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (quiesce_req !== 1'b0) begin n_bad++; $display("FAIL mr_qreq i=%0d got %b want 0", i, quiesce_req); end
      n_cmp++; if (domain_reset !== 4'b1111) begin n_bad++; $display("FAIL mr_dr i=%0d got %b want 1111", i, domain_reset); end
      n_cmp++; if (cause !== 2'b00) begin n_bad++; $display("FAIL mr_cause i=%0d got %b want 00", i, cause); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mr_busy i=%0d got %b want 1", i, busy); end
    end
    reset_n = 1'b1;
    repeat (10) step();
    n_cmp++; if (domain_reset !== 4'b1110) begin n_bad++; $display("FAIL mr_rel got %b want 1110", domain_reset); end
    reset_n = 1'b0; step();
    n_cmp++; if (domain_reset !== 4'b1111) begin n_bad++; $display("FAIL mr_rel_rst got %b want 1111", domain_reset); end
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL mr_ato got %b want 0", ack_timeout); end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_por();
    test_soft_ack();
    test_timeout();
    test_glitch();
    test_priority();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
